fsqrt_table_loader: RTL and testbench

Run-time writer for the 1024 x 36 coefficient table read by the square-root unit. Accepts a byte stream over a valid/ready handshake, packs every five bytes into one 36-bit entry `{c[22:0], g[12:0]}`, writes entries 0..1023 in order, then checks a trailing 8-bit checksum. Owns the dual-port table RAM and serves the square-root unit's 1-cycle-latency read port, so the table can be reloaded without rebuilding the memory image.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fsqrt_table_loader_if.sv | 18 +
 rtl/sqrt_table_ram.sv | 35 +++
 rtl/fsqrt_table_loader.sv | 150 +++++++++++++++
 tb/tb_fsqrt_table_loader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the square-root coefficient table and its loader.
//   TBL_DEPTH / TBL_WIDTH / TBL_AW : table geometry (1024 x 36, 10-bit index)
//   C_W / G_W                      : field widths of an entry {c, g}
//   tbl_state_t                    : loader state machine encoding
//   pack_entry                     : builds an entry from its two fields
// -----------------------------------------------------------------------------
package fpu_pkg;

    localparam int TBL_DEPTH = 1024;
    localparam int TBL_WIDTH = 36;
    localparam int TBL_AW    = $clog2(TBL_DEPTH);

    localparam int C_W = 23;
    localparam int G_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } tbl_state_t;

    function automatic logic [C_W+G_W-1:0] pack_entry(input logic [C_W-1:0] c,
                                                      input logic [G_W-1:0] g);
        return {c, g};
    endfunction

endpackage

// File: rtl/fsqrt_table_loader_if.sv
// -----------------------------------------------------------------------------
// fsqrt_table_loader_if
// Byte stream carrying a coefficient table image into the loader.
//   in_valid : byte offered on in_data (driven by the source)
//   in_data  : stream byte (driven by the source)
//   in_ready : loader accepts the byte when in_valid & in_ready
// Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface fsqrt_table_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/sqrt_table_ram.sv
// -----------------------------------------------------------------------------
// sqrt_table_ram
// Simple dual-port RAM holding the square-root coefficient table.
//   clk     : clock
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address, sampled every edge
//   rdata   : registered read data (read-first on an address collision)
// Contents are never cleared; the loader overwrites them entry by entry.
// -----------------------------------------------------------------------------
module sqrt_table_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 36,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read and write share one edge, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fsqrt_table_loader.sv
// -----------------------------------------------------------------------------
// fsqrt_table_loader
// Run-time writer for the square-root coefficient table. Packs every five
// stream bytes into one 36-bit entry {c, g}, writes entries 0..DEPTH-1 in
// order, then verifies a trailing checksum byte (sum of all bytes == 0 mod 256).
// Also serves the square-root unit's 1-cycle read port from the same RAM.
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse, (re)starts a load from entry 0
//   stream      : byte stream (slave side of fsqrt_table_loader_if)
//   rd_addr     : lookup index from the square-root unit
//   rd_data     : mem[rd_addr], registered
//   table_ready : table fully loaded and checksum good
//   load_err    : last load failed its checksum
//   wr_count    : entries written in the current load
// -----------------------------------------------------------------------------
module fsqrt_table_loader
    import fpu_pkg::*;
#(
    parameter int DEPTH = TBL_DEPTH,
    parameter int WIDTH = TBL_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    fsqrt_table_loader_if.slave  stream,
    input  logic [AW-1:0]        rd_addr,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 table_ready,
    output logic                 load_err,
    output logic [AW:0]          wr_count
);

    localparam logic [AW:0] LAST_ENTRY = (AW + 1)'(DEPTH - 1);

    tbl_state_t       state_q, state_d;
    logic [AW:0]      wr_count_q, wr_count_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       sum_q, sum_d, sum_next;
    logic             table_ready_q, table_ready_d;
    logic             load_err_q, load_err_d;
    logic             accept;
    logic             wr_en;
    logic             ram_we;
    logic [WIDTH-1:0] wr_data;

    // Only bytes 0..3 are held; byte 4 joins them combinationally on the write
    // edge. Byte 0 ends up in the top byte lane, where only its low nibble fits,
    // so its upper nibble falls off the top without any explicit masking.
    logic [WIDTH-9:0] asm_q;

    always_comb begin
        state_d       = state_q;
        wr_count_d    = wr_count_q;
        byte_idx_d    = byte_idx_q;
        sum_d         = sum_q;
        table_ready_d = table_ready_q;
        load_err_d    = load_err_q;
        wr_en         = 1'b0;

        stream.in_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
        accept          = stream.in_valid && stream.in_ready;
        sum_next        = sum_q + stream.in_data;

        if (start) begin
            // start wins over any byte offered in the same cycle
            state_d       = ST_LOAD;
            wr_count_d    = '0;
            byte_idx_d    = '0;
            sum_d         = '0;
            table_ready_d = 1'b0;
            load_err_d    = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept) begin
                        sum_d = sum_next;
                        if (byte_idx_q == 3'd4) begin
                            wr_en      = 1'b1;
                            wr_count_d = wr_count_q + 1'b1;
                            byte_idx_d = '0;
                            if (wr_count_q == LAST_ENTRY) begin
                                state_d = ST_CHECK;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        if (sum_next == 8'd0) begin
                            state_d       = ST_DONE;
                            table_ready_d = 1'b1;
                        end else begin
                            state_d    = ST_ERROR;
                            load_err_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wr_count_q    <= '0;
            byte_idx_q    <= '0;
            sum_q         <= '0;
            table_ready_q <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_count_q    <= wr_count_d;
            byte_idx_q    <= byte_idx_d;
            sum_q         <= sum_d;
            table_ready_q <= table_ready_d;
            load_err_q    <= load_err_d;
        end
    end

    // Assembly shift register carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            asm_q <= {asm_q[WIDTH-17:0], stream.in_data};
        end
    end

    assign wr_data = {asm_q, stream.in_data};
    assign ram_we  = wr_en && !rst;

    sqrt_table_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_count_q[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign table_ready = table_ready_q;
    assign load_err    = load_err_q;
    assign wr_count    = wr_count_q;

endmodule

// File: tb/tb_fsqrt_table_loader.sv
module tb_fsqrt_table_loader;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  rd_addr;
    logic [35:0] rd_data;
    logic        table_ready;
    logic        load_err;
    logic [10:0] wr_count;

    fsqrt_table_loader_if s_if ();

    fsqrt_table_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stream      (s_if),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .table_ready (table_ready),
        .load_err    (load_err),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] csum;

    typedef struct {
        logic [9:0]  addr;
        logic [35:0] data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [9:0]  addr;
        logic [35:0] exp;
    } rd_vec_t;
    rd_vec_t vecs[6];

    localparam logic [35:0] SALT_A = 36'hF_FFFF_FFFF;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] entry(input int i, input logic [35:0] salt);
        logic [22:0] c;
        logic [12:0] g;
        c = 23'(i * 3);
        g = 13'(i);
        return pack_entry(c, g) ^ salt;
    endfunction

    // Scoreboard: every RAM write is popped against the entry the bench pushed.
    always @(negedge clk) begin
        if (!rst && dut.ram_we) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 64'(dut.wr_count_q), 64'hFFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(dut.wr_count_q[9:0]), 64'(e.addr));
                check("wr_data", 64'(dut.wr_data), 64'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        while (gap > 0 && n < 8 && $urandom_range(99) < gap) begin
            s_if.in_valid = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        s_if.in_valid = 1'b1;
        s_if.in_data  = b;
        n = 0;
        while (!s_if.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_if.in_ready) begin
            check("ready_timeout", 64'(s_if.in_ready), 64'd1);
        end else begin
            csum += b;
            @(posedge clk); #1;
        end
        s_if.in_valid = 1'b0;
    endtask

    task automatic send_entry(input int addr, input logic [35:0] e, input logic [3:0] hi, input int gap);
        send_byte({hi, e[35:32]}, gap);
        send_byte(e[31:24], gap);
        send_byte(e[23:16], gap);
        send_byte(e[15:8], gap);
        sb.push_back('{10'(addr), e});
        send_byte(e[7:0], gap);
    endtask

    task automatic pulse_start(input logic with_byte);
        start         = 1'b1;
        s_if.in_valid = with_byte;
        s_if.in_data  = 8'hAA;
        @(posedge clk); #1;
        start         = 1'b0;
        s_if.in_valid = 1'b0;
        csum          = 8'd0;
    endtask

    task automatic load(input int n, input logic [35:0] salt, input logic [3:0] hi,
                        input int gap, input logic [7:0] delta);
        logic [7:0] k;
        for (int i = 0; i < n; i++) send_entry(i, entry(i, salt), hi, gap);
        if (n == 1024) begin
            check("wr_count_full", 64'(wr_count), 64'd1024);
            k = 8'd0 - csum + delta;
            send_byte(k, gap);
        end
    endtask

    task automatic read_chk(input string name, input logic [9:0] addr, input logic [35:0] exp);
        rd_addr = addr;
        @(posedge clk); #1;
        check(name, 64'(rd_data), 64'(exp));
    endtask

    task automatic read_table();
        for (int i = 0; i < 6; i++) read_chk("rd_vec", vecs[i].addr, vecs[i].exp);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0] e7;

        vecs[0] = '{10'd0,    entry(0, 36'd0)};
        vecs[1] = '{10'd5,    {23'd15, 13'd5}};
        vecs[2] = '{10'd7,    entry(7, 36'd0)};
        vecs[3] = '{10'd299,  entry(299, 36'd0)};
        vecs[4] = '{10'd512,  entry(512, 36'd0)};
        vecs[5] = '{10'd1023, entry(1023, 36'd0)};

        rst           = 1'b1;
        start         = 1'b0;
        s_if.in_valid = 1'b0;
        s_if.in_data  = 8'd0;
        rd_addr       = 10'd0;
        csum          = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",    64'(s_if.in_ready), 64'd0);
        check("rst_table_ready", 64'(table_ready),   64'd0);
        check("rst_load_err",    64'(load_err),      64'd0);
        check("rst_wr_count",    64'(wr_count),      64'd0);
        check("rst_state",       64'(dut.state_q),   64'(ST_IDLE));
        rst = 1'b0;

        // Clean full load
        pulse_start(1'b0);
        load(1024, 36'd0, 4'h0, 0, 8'd0);
        check("ok_table_ready", 64'(table_ready),   64'd1);
        check("ok_load_err",    64'(load_err),      64'd0);
        check("ok_state",       64'(dut.state_q),   64'(ST_DONE));
        check("ok_in_ready",    64'(s_if.in_ready), 64'd0);
        read_table();

        // Bad checksum
        pulse_start(1'b0);
        check("start_clears_ready", 64'(table_ready), 64'd0);
        load(1024, 36'd0, 4'h0, 0, 8'd1);
        check("bad_load_err",    64'(load_err),      64'd1);
        check("bad_table_ready", 64'(table_ready),   64'd0);
        check("bad_state",       64'(dut.state_q),   64'(ST_ERROR));
        check("bad_in_ready",    64'(s_if.in_ready), 64'd0);

        // Gapped stream, byte 0 upper nibble set (summed but not stored)
        pulse_start(1'b0);
        check("start_clears_err", 64'(load_err), 64'd0);
        load(1024, 36'd0, 4'hF, 50, 8'd0);
        check("gap_table_ready", 64'(table_ready), 64'd1);
        check("gap_load_err",    64'(load_err),    64'd0);
        read_table();

        // Restart after 300 entries of different data; byte offered with start is dropped
        pulse_start(1'b0);
        load(300, SALT_A, 4'h0, 0, 8'd0);
        check("rs_wr_count_300", 64'(wr_count), 64'd300);
        read_chk("rs_old_299", 10'd299, entry(299, SALT_A));
        pulse_start(1'b1);
        check("rs_wr_count_0", 64'(wr_count),    64'd0);
        check("rs_state",      64'(dut.state_q), 64'(ST_LOAD));
        load(1024, 36'd0, 4'h0, 0, 8'd0);
        check("rs_table_ready", 64'(table_ready), 64'd1);
        read_chk("rs_new_299", 10'd299, entry(299, 36'd0));

        // Reset in the middle of entry 500
        pulse_start(1'b0);
        load(500, 36'd0, 4'h0, 0, 8'd0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_in_ready",    64'(s_if.in_ready), 64'd0);
        check("mr_table_ready", 64'(table_ready),   64'd0);
        check("mr_load_err",    64'(load_err),      64'd0);
        check("mr_wr_count",    64'(wr_count),      64'd0);
        check("mr_state",       64'(dut.state_q),   64'(ST_IDLE));
        rst = 1'b0;
        pulse_start(1'b0);
        load(1024, 36'd0, 4'h0, 0, 8'd0);
        check("mr_reload_ready", 64'(table_ready), 64'd1);

        // Read-first collision on entry 7
        pulse_start(1'b0);
        load(7, 36'd0, 4'h0, 0, 8'd0);
        e7 = 36'h123456789;
        send_byte({4'h0, e7[35:32]}, 0);
        send_byte(e7[31:24], 0);
        send_byte(e7[23:16], 0);
        send_byte(e7[15:8], 0);
        rd_addr = 10'd7;
        sb.push_back('{10'd7, e7});
        send_byte(e7[7:0], 0);
        check("col_old", 64'(rd_data), 64'(entry(7, 36'd0)));
        @(posedge clk); #1;
        check("col_new", 64'(rd_data), 64'(e7));
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
